axi_lite_wr_arbiter: RTL and testbench

Two-master round-robin arbiter for a single AXI4-Lite write path (AW, W and B channels) in front of one slave write port, which is the write-data/strobe capture stage. It grants the write path to one master per transaction and routes that master's AW and W channels to the slave. It returns the slave's B response to the same master and holds the grant until the response handshake completes. The result is a write path with no interleaving, reordering or mixing of data between masters.

---
 rtl/axi_lite_wr_arbiter_if.sv | 44 ++++
 rtl/axi_lite_wr_arbiter.sv | 104 ++++++++++
 tb/tb_axi_lite_wr_arbiter.sv | 403 ++++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/axi_lite_wr_arbiter_if.sv
// Write-path bundle between two AXI4-Lite masters, the arbiter and one write slave.
// Ports: m_* are the two master-facing channels (element i = master i), s_* the slave-facing channel.
// Modports: master = the arbiter's view (it masters the downstream port), slave = the surrounding agents.
interface axi_lite_wr_arbiter_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
);
  // Packed [1:0][W-1:0] arrays flatten so master i occupies [i*W +: W].
  logic [1:0]                       m_awvalid;
  logic [1:0][ADDR_WIDTH-1:0]       m_awaddr;
  logic [1:0]                       m_awready;
  logic [1:0]                       m_wvalid;
  logic [1:0][DATA_WIDTH-1:0]       m_wdata;
  logic [1:0][DATA_WIDTH/8-1:0]     m_wstrb;
  logic [1:0]                       m_wready;
  logic [1:0]                       m_bvalid;
  logic [1:0][1:0]                  m_bresp;
  logic [1:0]                       m_bready;

  logic                             s_awvalid;
  logic [ADDR_WIDTH-1:0]            s_awaddr;
  logic                             s_awready;
  logic                             s_wvalid;
  logic [DATA_WIDTH-1:0]            s_wdata;
  logic [DATA_WIDTH/8-1:0]          s_wstrb;
  logic                             s_wready;
  logic                             s_bvalid;
  logic [1:0]                       s_bresp;
  logic                             s_bready;

  modport master (
    input  m_awvalid, m_awaddr, m_wvalid, m_wdata, m_wstrb, m_bready,
    input  s_awready, s_wready, s_bvalid, s_bresp,
    output m_awready, m_wready, m_bvalid, m_bresp,
    output s_awvalid, s_awaddr, s_wvalid, s_wdata, s_wstrb, s_bready
  );

  modport slave (
    output m_awvalid, m_awaddr, m_wvalid, m_wdata, m_wstrb, m_bready,
    output s_awready, s_wready, s_bvalid, s_bresp,
    input  m_awready, m_wready, m_bvalid, m_bresp,
    input  s_awvalid, s_awaddr, s_wvalid, s_wdata, s_wstrb, s_bready
  );
endinterface

// File: rtl/axi_lite_wr_arbiter.sv
// Two-master round-robin arbiter for one AXI4-Lite write path; one whole AW/W/B transaction per grant.
// Ports: aclk, aresetn (async, active low), bus (master modport), grant (owner index), busy (transaction open).
// Latency: forwarding starts the cycle after a request is sampled; slave stalls extend XFER/RESP; data is never buffered.
module axi_lite_wr_arbiter (
  input  logic                  aclk,
  input  logic                  aresetn,
  axi_lite_wr_arbiter_if.master bus,
  output logic                  grant,
  output logic                  busy
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    XFER = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t state, state_nxt;
  logic   grant_q, grant_nxt;
  logic   last_q, last_nxt;
  logic   aw_done_q, aw_done_nxt;
  logic   w_done_q, w_done_nxt;
  logic   aw_hs, w_hs;

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      state     <= IDLE;
      grant_q   <= 1'b0;
      last_q    <= 1'b1;  // master 0 wins the first contested arbitration
      aw_done_q <= 1'b0;
      w_done_q  <= 1'b0;
    end else begin
      state     <= state_nxt;
      grant_q   <= grant_nxt;
      last_q    <= last_nxt;
      aw_done_q <= aw_done_nxt;
      w_done_q  <= w_done_nxt;
    end
  end

  always_comb begin
    state_nxt     = state;
    grant_nxt     = grant_q;
    last_nxt      = last_q;
    aw_done_nxt   = aw_done_q;
    w_done_nxt    = w_done_q;
    aw_hs         = 1'b0;
    w_hs          = 1'b0;
    bus.m_awready = '0;
    bus.m_wready  = '0;
    bus.m_bvalid  = '0;
    bus.m_bresp   = '0;
    bus.s_awvalid = 1'b0;
    bus.s_awaddr  = '0;
    bus.s_wvalid  = 1'b0;
    bus.s_wdata   = '0;
    bus.s_wstrb   = '0;
    bus.s_bready  = 1'b0;

    case (state)
      IDLE: begin
        // Only AWVALID counts as a request; a lone WVALID waits for its address.
        if (|bus.m_awvalid) begin
          grant_nxt   = (&bus.m_awvalid) ? ~last_q : bus.m_awvalid[1];
          aw_done_nxt = 1'b0;
          w_done_nxt  = 1'b0;
          state_nxt   = XFER;
        end
      end

      XFER: begin
        bus.s_awvalid          = bus.m_awvalid[grant_q] & ~aw_done_q;
        bus.s_awaddr           = bus.m_awaddr[grant_q];
        bus.m_awready[grant_q] = bus.s_awready & ~aw_done_q;
        bus.s_wvalid           = bus.m_wvalid[grant_q] & ~w_done_q;
        bus.s_wdata            = bus.m_wdata[grant_q];
        bus.s_wstrb            = bus.m_wstrb[grant_q];
        bus.m_wready[grant_q]  = bus.s_wready & ~w_done_q;
        aw_hs                  = bus.s_awvalid & bus.s_awready;
        w_hs                   = bus.s_wvalid & bus.s_wready;
        if (aw_hs) aw_done_nxt = 1'b1;
        if (w_hs)  w_done_nxt  = 1'b1;
        // AW and W may finish in either order or together.
        if ((aw_done_q | aw_hs) & (w_done_q | w_hs)) state_nxt = RESP;
      end

      RESP: begin
        bus.s_bready          = bus.m_bready[grant_q];
        bus.m_bvalid[grant_q] = bus.s_bvalid;
        bus.m_bresp[grant_q]  = bus.s_bresp;
        if (bus.s_bvalid & bus.s_bready) begin
          last_nxt  = grant_q;
          state_nxt = IDLE;
        end
      end

      default: state_nxt = IDLE;
    endcase
  end

  assign grant = grant_q;
  assign busy  = (state != IDLE);

endmodule

// File: tb/tb_axi_lite_wr_arbiter.sv
// Self-checking bench for axi_lite_wr_arbiter: scripted scenarios over simple master/slave agents.
// Ports: none; instantiates the interface and the arbiter, drives aclk with a 10-unit period.
// Expected slave-side beats and master responses are queued at stimulus time and popped on handshakes.
module tb_axi_lite_wr_arbiter;

  typedef struct packed {
    logic        g;
    logic [31:0] addr;
    logic [31:0] data;
    logic [3:0]  strb;
    logic [1:0]  resp;
  } txn_t;

  logic aclk = 1'b0;
  logic aresetn = 1'b0;
  logic grant, busy;

  axi_lite_wr_arbiter_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) bus ();

  axi_lite_wr_arbiter dut (
    .aclk    (aclk),
    .aresetn (aresetn),
    .bus     (bus),
    .grant   (grant),
    .busy    (busy)
  );

  always #5 aclk = ~aclk;

  int checks = 0;
  int failures = 0;

  txn_t mq0[$], mq1[$], exp_aw[$], exp_w[$], exp_b[$];
  logic       awready_k, wready_k;
  logic [1:0] bready_k, bresp_k;
  logic [1:0] aw_acc, w_acc;
  int         aw_cnt, w_cnt, b_cnt;

  function automatic txn_t mk(logic g, logic [31:0] a, logic [31:0] d, logic [3:0] s, logic [1:0] r);
    txn_t t;
    t.g = g; t.addr = a; t.data = d; t.strb = s; t.resp = r;
    return t;
  endfunction

  task automatic push_txn(txn_t t);
    if (t.g) mq1.push_back(t);
    else     mq0.push_back(t);
    exp_aw.push_back(t);
    exp_w.push_back(t);
    exp_b.push_back(t);
  endtask

  function automatic logic outs_or();
    return |{bus.m_awready, bus.m_wready, bus.m_bvalid, bus.m_bresp, bus.s_awvalid, bus.s_awaddr,
             bus.s_wvalid, bus.s_wdata, bus.s_wstrb, bus.s_bready, grant, busy};
  endfunction

  // One clock of the agents: drive at negedge, sample handshakes 1 unit later, return at negedge+2.
  task automatic tick();
    txn_t t, e;
    @(negedge aclk);
    if (!aresetn) begin
      bus.m_awvalid = '0;
      bus.m_wvalid  = '0;
      bus.s_bvalid  = 1'b0;
      aw_acc = '0; w_acc = '0;
      aw_cnt = 0; w_cnt = 0; b_cnt = 0;
      mq0.delete(); mq1.delete();
      exp_aw.delete(); exp_w.delete(); exp_b.delete();
    end else begin
      for (int i = 0; i < 2; i++) begin
        if (aw_acc[i]) bus.m_awvalid[i] = 1'b0;
        if (w_acc[i])  bus.m_wvalid[i]  = 1'b0;
        if (!bus.m_awvalid[i] && !bus.m_wvalid[i]) begin
          if (i == 0 && mq0.size() > 0) begin
            t = mq0.pop_front();
            bus.m_awaddr[0] = t.addr; bus.m_wdata[0] = t.data; bus.m_wstrb[0] = t.strb;
            bus.m_awvalid[0] = 1'b1; bus.m_wvalid[0] = 1'b1;
          end else if (i == 1 && mq1.size() > 0) begin
            t = mq1.pop_front();
            bus.m_awaddr[1] = t.addr; bus.m_wdata[1] = t.data; bus.m_wstrb[1] = t.strb;
            bus.m_awvalid[1] = 1'b1; bus.m_wvalid[1] = 1'b1;
          end
        end
      end
      aw_acc = '0; w_acc = '0;
      bus.s_bvalid = (aw_cnt > b_cnt) && (w_cnt > b_cnt);
    end
    bus.s_awready = awready_k;
    bus.s_wready  = wready_k;
    bus.m_bready  = bready_k;
    bus.s_bresp   = bresp_k;
    #1;
    if (aresetn) begin
      aw_acc = bus.m_awvalid & bus.m_awready;
      w_acc  = bus.m_wvalid & bus.m_wready;
      if (bus.s_awvalid && bus.s_awready) begin
        aw_cnt++;
        checks++;
        if (exp_aw.size() == 0) begin
          failures++;
          $display("FAIL sb_aw: unexpected AW addr=%h, none required", bus.s_awaddr);
        end else begin
          e = exp_aw.pop_front();
          if (bus.s_awaddr !== e.addr || grant !== e.g) begin
            failures++;
            $display("FAIL sb_aw: got grant=%0d addr=%h, required grant=%0d addr=%h", grant, bus.s_awaddr, e.g, e.addr);
          end
        end
      end
      if (bus.s_wvalid && bus.s_wready) begin
        w_cnt++;
        checks++;
        if (exp_w.size() == 0) begin
          failures++;
          $display("FAIL sb_w: unexpected W data=%h, none required", bus.s_wdata);
        end else begin
          e = exp_w.pop_front();
          if (bus.s_wdata !== e.data || bus.s_wstrb !== e.strb || grant !== e.g) begin
            failures++;
            $display("FAIL sb_w: got grant=%0d data=%h strb=%h, required grant=%0d data=%h strb=%h",
                     grant, bus.s_wdata, bus.s_wstrb, e.g, e.data, e.strb);
          end
        end
      end
      if (bus.s_bvalid && bus.s_bready) b_cnt++;
      for (int i = 0; i < 2; i++) begin
        if (bus.m_bvalid[i] && bus.m_bready[i]) begin
          checks++;
          if (exp_b.size() == 0) begin
            failures++;
            $display("FAIL sb_b: unexpected B on master %0d", i);
          end else begin
            e = exp_b.pop_front();
            if (e.g !== 1'(i) || bus.m_bresp[i] !== e.resp || bus.m_bresp[1-i] !== 2'b00) begin
              failures++;
              $display("FAIL sb_b: got master=%0d bresp=%b, required master=%0d resp=%b other slot 00",
                       i, bus.m_bresp, e.g, e.resp);
            end
          end
        end
      end
    end
    #1;
  endtask

  task automatic do_reset();
    awready_k = 1'b1; wready_k = 1'b1; bready_k = 2'b11; bresp_k = 2'b00;
    aresetn = 1'b0;
    tick();
    tick();
    aresetn = 1'b1;
  endtask

  task automatic test_reset();
    awready_k = 1'b1; wready_k = 1'b1; bready_k = 2'b11; bresp_k = 2'b00;
    aresetn = 1'b0;
    tick();
    checks++;
    if (outs_or() !== 1'b0) begin
      failures++;
      $display("FAIL reset_outputs: some output nonzero in reset (grant=%0d busy=%0d s_awvalid=%0d)", grant, busy, bus.s_awvalid);
    end
    aresetn = 1'b1;
    tick();
    checks++;
    if (outs_or() !== 1'b0) begin
      failures++;
      $display("FAIL idle_outputs: some output nonzero in IDLE (grant=%0d busy=%0d)", grant, busy);
    end
  endtask

  task automatic test_single_write();
    logic bad1 = 1'b0;
    push_txn(mk(1'b0, 32'h10, 32'hDEADBEEF, 4'hF, 2'b00));
    tick();  // request cycle
    bad1 |= bus.m_awready[1] | bus.m_wready[1];
    checks++;
    if (busy !== 1'b0 || bus.s_awvalid !== 1'b0 || bus.s_wvalid !== 1'b0) begin
      failures++;
      $display("FAIL single_c0: busy=%0d s_awvalid=%0d s_wvalid=%0d, required 0 0 0", busy, bus.s_awvalid, bus.s_wvalid);
    end
    tick();  // XFER
    bad1 |= bus.m_awready[1] | bus.m_wready[1];
    checks++;
    if (!(bus.s_awvalid && bus.s_awready && bus.s_wvalid && bus.s_wready) || bus.s_awaddr !== 32'h10 ||
        bus.s_wdata !== 32'hDEADBEEF || bus.s_wstrb !== 4'hF || grant !== 1'b0 || busy !== 1'b1) begin
      failures++;
      $display("FAIL single_c1: aw=%0d w=%0d addr=%h data=%h strb=%h grant=%0d busy=%0d, required 1 1 10 deadbeef f 0 1",
               bus.s_awvalid, bus.s_wvalid, bus.s_awaddr, bus.s_wdata, bus.s_wstrb, grant, busy);
    end
    tick();  // RESP
    bad1 |= bus.m_awready[1] | bus.m_wready[1];
    checks++;
    if (bus.m_bvalid !== 2'b01 || bus.m_bresp !== 4'b0000 || bus.s_bready !== 1'b1) begin
      failures++;
      $display("FAIL single_c2: m_bvalid=%b m_bresp=%b s_bready=%0d, required 01 0000 1", bus.m_bvalid, bus.m_bresp, bus.s_bready);
    end
    tick();
    bad1 |= bus.m_awready[1] | bus.m_wready[1];
    checks++;
    if (busy !== 1'b0) begin
      failures++;
      $display("FAIL single_c3: busy=%0d, required 0", busy);
    end
    checks++;
    if (bad1 !== 1'b0) begin
      failures++;
      $display("FAIL single_m1_ready: master 1 ready seen=%0d, required 0", bad1);
    end
  endtask

  task automatic test_simultaneous();
    logic [3:0] gseq = '0;
    int         n = 0;
    logic       bad = 1'b0;
    int         k = 0;
    do_reset();
    push_txn(mk(1'b0, 32'h100, 32'hA0A0_0001, 4'hF, 2'b00));
    push_txn(mk(1'b1, 32'h200, 32'hB0B0_0002, 4'hC, 2'b00));
    push_txn(mk(1'b0, 32'h100, 32'hA0A0_0003, 4'h3, 2'b00));
    push_txn(mk(1'b1, 32'h200, 32'hB0B0_0004, 4'h1, 2'b00));
    do begin
      tick();
      k++;
      if (bus.s_awvalid && bus.s_awready && n < 4) begin
        gseq[n] = grant;
        n++;
      end
      if (busy) bad |= bus.m_awready[~grant] | bus.m_wready[~grant] | bus.m_bvalid[~grant];
    end while (((exp_aw.size() + exp_w.size() + exp_b.size()) != 0 || busy) && k < 80);
    checks++;
    if ((exp_aw.size() + exp_w.size() + exp_b.size()) != 0 || busy) begin
      failures++;
      $display("FAIL simul_drain: %0d expectations left after %0d cycles, required 0", exp_aw.size() + exp_b.size(), k);
    end
    checks++;
    if (n != 4 || gseq !== 4'b1010) begin
      failures++;
      $display("FAIL simul_grants: got %0d grants seq(lsb first)=%b, required 4 seq=1010", n, gseq);
    end
    checks++;
    if (bad !== 1'b0) begin
      failures++;
      $display("FAIL simul_nongranted: non-granted ready/bvalid seen=%0d, required 0", bad);
    end
  endtask

  task automatic test_w_before_aw();
    do_reset();
    awready_k = 1'b0;
    push_txn(mk(1'b0, 32'h40, 32'h1234_5678, 4'h3, 2'b00));
    tick();  // request cycle
    tick();  // XFER 1
    checks++;
    if (!(bus.s_wvalid && bus.s_wready) || bus.s_awvalid !== 1'b1 || busy !== 1'b1) begin
      failures++;
      $display("FAIL wfirst_x1: s_wvalid=%0d s_awvalid=%0d busy=%0d, required 1 1 1", bus.s_wvalid, bus.s_awvalid, busy);
    end
    for (int c = 2; c <= 3; c++) begin
      tick();
      checks++;
      if (bus.s_wvalid !== 1'b0 || bus.s_awvalid !== 1'b1 || busy !== 1'b1 || bus.m_bvalid !== 2'b00) begin
        failures++;
        $display("FAIL wfirst_x%0d: s_wvalid=%0d s_awvalid=%0d busy=%0d m_bvalid=%b, required 0 1 1 00",
                 c, bus.s_wvalid, bus.s_awvalid, busy, bus.m_bvalid);
      end
    end
    awready_k = 1'b1;
    tick();
    checks++;
    if (!(bus.s_awvalid && bus.s_awready) || bus.s_wvalid !== 1'b0) begin
      failures++;
      $display("FAIL wfirst_aw: s_awvalid=%0d s_awready=%0d s_wvalid=%0d, required 1 1 0", bus.s_awvalid, bus.s_awready, bus.s_wvalid);
    end
    tick();
    checks++;
    if (bus.m_bvalid !== 2'b01 || bus.s_awvalid !== 1'b0) begin
      failures++;
      $display("FAIL wfirst_resp: m_bvalid=%b s_awvalid=%0d, required 01 0", bus.m_bvalid, bus.s_awvalid);
    end
    tick();
    checks++;
    if (busy !== 1'b0) begin
      failures++;
      $display("FAIL wfirst_done: busy=%0d, required 0", busy);
    end
  endtask

  task automatic test_error_resp();
    int k = 0;
    do_reset();
    bresp_k  = 2'b10;
    bready_k = 2'b01;
    push_txn(mk(1'b1, 32'h300, 32'h0BAD_F00D, 4'hF, 2'b10));
    do begin
      tick();
      k++;
    end while (bus.m_bvalid[1] !== 1'b1 && k < 20);
    checks++;
    if (bus.m_bvalid[1] !== 1'b1) begin
      failures++;
      $display("FAIL err_wait: m_bvalid[1] not seen in %0d cycles, required within 20", k);
    end
    for (int c = 0; c < 2; c++) begin
      if (c > 0) tick();
      checks++;
      if (bus.m_bvalid !== 2'b10 || bus.m_bresp !== 4'b1000 || busy !== 1'b1 || grant !== 1'b1) begin
        failures++;
        $display("FAIL err_hold%0d: m_bvalid=%b m_bresp=%b busy=%0d grant=%0d, required 10 1000 1 1",
                 c, bus.m_bvalid, bus.m_bresp, busy, grant);
      end
    end
    bready_k = 2'b11;
    tick();
    checks++;
    if (!(bus.m_bvalid[1] && bus.m_bready[1]) || busy !== 1'b1) begin
      failures++;
      $display("FAIL err_hs: m_bvalid=%b m_bready=%b busy=%0d, required bvalid[1]=1 bready[1]=1 busy=1",
               bus.m_bvalid, bus.m_bready, busy);
    end
    tick();
    checks++;
    if (busy !== 1'b0) begin
      failures++;
      $display("FAIL err_release: busy=%0d, required 0", busy);
    end
  endtask

  task automatic test_reset_mid_xfer();
    int   k = 0;
    int   n = 0;
    logic first_g = 1'b1;
    do_reset();
    awready_k = 1'b0;
    wready_k  = 1'b0;
    push_txn(mk(1'b1, 32'h700, 32'h7777_7777, 4'hF, 2'b00));
    tick();
    tick();
    checks++;
    if (busy !== 1'b1 || grant !== 1'b1 || bus.s_awvalid !== 1'b1) begin
      failures++;
      $display("FAIL rst_pre: busy=%0d grant=%0d s_awvalid=%0d, required 1 1 1", busy, grant, bus.s_awvalid);
    end
    #1 aresetn = 1'b0;
    #1;
    checks++;
    if (outs_or() !== 1'b0) begin
      failures++;
      $display("FAIL rst_async: outputs nonzero after mid-XFER reset (busy=%0d grant=%0d s_awvalid=%0d)", busy, grant, bus.s_awvalid);
    end
    tick();
    tick();
    aresetn = 1'b1;
    awready_k = 1'b1; wready_k = 1'b1;
    push_txn(mk(1'b0, 32'h500, 32'h5555_0000, 4'hF, 2'b00));
    push_txn(mk(1'b1, 32'h600, 32'h6666_0000, 4'hF, 2'b00));
    do begin
      tick();
      k++;
      if (bus.s_awvalid && bus.s_awready && n == 0) begin
        first_g = grant;
        n++;
      end
    end while (((exp_aw.size() + exp_w.size() + exp_b.size()) != 0 || busy) && k < 40);
    checks++;
    if (n != 1 || first_g !== 1'b0) begin
      failures++;
      $display("FAIL rst_first_grant: got grant=%0d (seen=%0d), required 0", first_g, n);
    end
    checks++;
    if ((exp_aw.size() + exp_w.size() + exp_b.size()) != 0 || busy) begin
      failures++;
      $display("FAIL rst_drain: %0d expectations left, required 0", exp_aw.size() + exp_b.size());
    end
  endtask

  initial begin
    bus.m_awvalid = '0; bus.m_awaddr = '0; bus.m_wvalid = '0; bus.m_wdata = '0; bus.m_wstrb = '0;
    bus.m_bready = '0; bus.s_awready = 1'b0; bus.s_wready = 1'b0; bus.s_bvalid = 1'b0; bus.s_bresp = '0;
    aw_acc = '0; w_acc = '0; aw_cnt = 0; w_cnt = 0; b_cnt = 0;
    test_reset();
    test_single_write();
    test_simultaneous();
    test_w_before_aw();
    test_error_resp();
    test_reset_mid_xfer();
    checks++;
    if ((exp_aw.size() + exp_w.size() + exp_b.size()) != 0) begin
      failures++;
      $display("FAIL final_drain: aw=%0d w=%0d b=%0d left, required 0", exp_aw.size(), exp_w.size(), exp_b.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
